// File: rtl/chunked_serial_adder_if.sv
// Handshake and data bundle for chunked_serial_adder.
// Defining CHUNKED_ADDER_OVF_EN adds the signed-overflow flag ovf.
interface chunked_serial_adder_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             busy;
`ifdef CHUNKED_ADDER_OVF_EN
   logic             ovf;

   modport master (output in_valid, a, b, cin, out_ready,
                   input  in_ready, out_valid, sum, cout, busy, ovf);
   modport slave  (input  in_valid, a, b, cin, out_ready,
                   output in_ready, out_valid, sum, cout, busy, ovf);
`else
   modport master (output in_valid, a, b, cin, out_ready,
                   input  in_ready, out_valid, sum, cout, busy);
   modport slave  (input  in_valid, a, b, cin, out_ready,
                   output in_ready, out_valid, sum, cout, busy);
`endif
endinterface

// File: rtl/chunked_serial_adder.sv
// Multi-cycle WIDTH-bit adder sharing one CHUNK-bit ripple slice, one op in flight.
// Optional feature macro: CHUNKED_ADDER_OVF_EN (adds registered signed-overflow output).
module chunked_serial_adder #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   chunked_serial_adder_if.slave   bus
);
   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
      $error("chunked_serial_adder: WIDTH must be >= 1 and a multiple of CHUNK");
   end
   if ($bits(bus.a) != WIDTH) begin : g_bad_bus
      $error("chunked_serial_adder: interface WIDTH does not match module WIDTH");
   end

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t            state_q, state_d;
   logic [IDXW-1:0]   idx_q, idx_d;
   logic              carry_q, carry_d;
   logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, sum_q, sum_d;
   logic              cout_q, cout_d;
   logic              out_valid_q, out_valid_d;
   logic              in_ready_q, in_ready_d;
   logic              busy_q, busy_d;
   logic              ovf_q, ovf_d;

   logic [CHUNK-1:0]  op_a, op_b, half_s, half_c, slice_s;
   logic [CHUNK:0]    slice_c;

   assign op_a   = a_q[int'(idx_q)*CHUNK +: CHUNK];
   assign op_b   = b_q[int'(idx_q)*CHUNK +: CHUNK];
   assign half_s = op_a ^ op_b;
   assign half_c = op_a & op_b;

   // Second half-adder stage per bit, with the two carries merged by an OR.
   always_comb begin
      slice_c    = '0;
      slice_s    = '0;
      slice_c[0] = carry_q;
      for (int i = 0; i < CHUNK; i++) begin
         slice_s[i]   = half_s[i] ^ slice_c[i];
         slice_c[i+1] = half_c[i] | (half_s[i] & slice_c[i]);
      end
   end

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      carry_d     = carry_q;
      a_d         = a_q;
      b_d         = b_q;
      sum_d       = sum_q;
      cout_d      = cout_q;
      out_valid_d = out_valid_q;
      in_ready_d  = in_ready_q;
      busy_d      = busy_q;
      ovf_d       = ovf_q;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               a_d        = bus.a;
               b_d        = bus.b;
               carry_d    = bus.cin;
               idx_d      = '0;
               sum_d      = '0;
               cout_d     = 1'b0;
               ovf_d      = 1'b0;
               in_ready_d = 1'b0;
               busy_d     = 1'b1;
               state_d    = CALC;
            end
         end
         CALC: begin
            sum_d[int'(idx_q)*CHUNK +: CHUNK] = slice_s;
            carry_d = slice_c[CHUNK];
            idx_d   = idx_q + IDXW'(1);
            if (idx_q == IDXW'(NCHUNK - 1)) begin
               cout_d      = slice_c[CHUNK];
               ovf_d       = slice_c[CHUNK] ^ slice_c[CHUNK-1];
               out_valid_d = 1'b1;
               idx_d       = '0;
               state_d     = DONE;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               busy_d      = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Reset drops any in-flight operation; nothing partial is ever presented.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         carry_q     <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         sum_q       <= '0;
         cout_q      <= 1'b0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
         busy_q      <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         carry_q     <= carry_d;
         a_q         <= a_d;
         b_q         <= b_d;
         sum_q       <= sum_d;
         cout_q      <= cout_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
         busy_q      <= busy_d;
         ovf_q       <= ovf_d;
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.sum       = sum_q;
   assign bus.cout      = cout_q;
   assign bus.busy      = busy_q;
`ifdef CHUNKED_ADDER_OVF_EN
   assign bus.ovf       = ovf_q;
`else
   logic unused_ovf;
   assign unused_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Randomised self-checking bench for chunked_serial_adder at 16/4, 8/8 and 32/1.
// Optional ovf checks are compiled in when CHUNKED_ADDER_OVF_EN is defined.
module tb_chunked_serial_adder;
   logic clk;
   logic rst;
   int   vectors;
   int   miscompares;

   chunked_serial_adder_if #(.WIDTH(16)) bus16 ();
   chunked_serial_adder_if #(.WIDTH(8))  bus8  ();
   chunked_serial_adder_if #(.WIDTH(32)) bus32 ();

   chunked_serial_adder #(.WIDTH(16), .CHUNK(4)) u_dut   (.clk(clk), .rst(rst), .bus(bus16));
   chunked_serial_adder #(.WIDTH(8),  .CHUNK(8)) u_dut8  (.clk(clk), .rst(rst), .bus(bus8));
   chunked_serial_adder #(.WIDTH(32), .CHUNK(1)) u_dut32 (.clk(clk), .rst(rst), .bus(bus32));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: plain integer addition, {cout, sum} truncated to w bits.
   function automatic logic [32:0] ref_add(input int w, input logic [31:0] a, input logic [31:0] b,
                                           input logic cin);
      logic [32:0] full;
      logic [32:0] mask;
      full = {1'b0, a} + {1'b0, b} + {32'd0, cin};
      mask = (33'd1 << w) - 33'd1;
      return {full[w], 32'(full & mask)};
   endfunction

   function automatic logic ref_ovf(input int w, input logic [31:0] a, input logic [31:0] b,
                                    input logic [31:0] s);
      return (a[w-1] == b[w-1]) && (s[w-1] != a[w-1]);
   endfunction

   // Drives one op on the 16-bit instance and reports what it observed.
   task automatic run_op16(input logic [15:0] a, input logic [15:0] b, input logic cin,
                           input int stall, output logic [15:0] s, output logic co,
                           output logic ov, output int lat);
      int guard;
      guard = 0;
      while (bus16.in_ready !== 1'b1 && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      bus16.a = a;
      bus16.b = b;
      bus16.cin = cin;
      bus16.in_valid = 1'b1;
      @(negedge clk);
      bus16.in_valid = 1'b0;
      bus16.a = 16'($urandom);
      bus16.b = 16'($urandom);
      bus16.cin = 1'($urandom);
      lat = 0;
      while (bus16.out_valid !== 1'b1 && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      repeat (stall) @(negedge clk);
      s  = bus16.sum;
      co = bus16.cout;
`ifdef CHUNKED_ADDER_OVF_EN
      ov = bus16.ovf;
`else
      ov = 1'b0;
`endif
      bus16.out_ready = 1'b1;
      @(negedge clk);
      bus16.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      vectors += 5;
      if (bus16.in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_in_ready: got %b expected 1", bus16.in_ready); end
      if (bus16.out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_out_valid: got %b expected 0", bus16.out_valid); end
      if (bus16.sum !== 16'h0) begin miscompares++; $display("[TB] FAIL reset_sum: got %h expected 0000", bus16.sum); end
      if (bus16.cout !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_cout: got %b expected 0", bus16.cout); end
      if (bus16.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b expected 0", bus16.busy); end
`ifdef CHUNKED_ADDER_OVF_EN
      vectors++;
      if (bus16.ovf !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ovf: got %b expected 0", bus16.ovf); end
`endif
   endtask

   task automatic test_basic();
      logic [15:0] s;
      logic co, ov;
      int lat;
      run_op16(16'h1234, 16'h0FFF, 1'b0, 0, s, co, ov, lat);
      vectors += 5;
      if (s !== 16'h2233) begin miscompares++; $display("[TB] FAIL basic_sum: got %h expected 2233", s); end
      if (co !== 1'b0) begin miscompares++; $display("[TB] FAIL basic_cout: got %b expected 0", co); end
      if (lat != 4) begin miscompares++; $display("[TB] FAIL basic_latency: got %0d expected 4", lat); end
      if (bus16.in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL basic_in_ready_after: got %b expected 1", bus16.in_ready); end
      if (bus16.out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL basic_out_valid_after: got %b expected 0", bus16.out_valid); end
   endtask

   task automatic test_wrap();
      logic [15:0] s;
      logic co, ov;
      int lat;
      run_op16(16'hFFFF, 16'h0000, 1'b1, 0, s, co, ov, lat);
      vectors += 2;
      if (s !== 16'h0000) begin miscompares++; $display("[TB] FAIL wrap1_sum: got %h expected 0000", s); end
      if (co !== 1'b1) begin miscompares++; $display("[TB] FAIL wrap1_cout: got %b expected 1", co); end
      run_op16(16'hFFFF, 16'hFFFF, 1'b1, 1, s, co, ov, lat);
      vectors += 2;
      if (s !== 16'hFFFF) begin miscompares++; $display("[TB] FAIL wrap2_sum: got %h expected ffff", s); end
      if (co !== 1'b1) begin miscompares++; $display("[TB] FAIL wrap2_cout: got %b expected 1", co); end
   endtask

   task automatic test_backpressure();
      int lat;
      bus16.a = 16'h00FF;
      bus16.b = 16'h0001;
      bus16.cin = 1'b0;
      bus16.in_valid = 1'b1;
      @(negedge clk);
      bus16.in_valid = 1'b0;
      lat = 0;
      while (bus16.out_valid !== 1'b1 && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      vectors++;
      if (lat != 4) begin miscompares++; $display("[TB] FAIL bp_latency: got %0d expected 4", lat); end
      for (int i = 0; i < 10; i++) begin
         vectors += 3;
         if (bus16.sum !== 16'h0100) begin miscompares++; $display("[TB] FAIL bp_sum_hold[%0d]: got %h expected 0100", i, bus16.sum); end
         if (bus16.out_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL bp_valid_hold[%0d]: got %b expected 1", i, bus16.out_valid); end
         if (bus16.in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_in_ready[%0d]: got %b expected 0", i, bus16.in_ready); end
         bus16.in_valid = (i == 3);
         bus16.a = 16'hAAAA;
         @(negedge clk);
      end
      bus16.in_valid = 1'b0;
      bus16.out_ready = 1'b1;
      @(negedge clk);
      bus16.out_ready = 1'b0;
      repeat (6) @(negedge clk);
      vectors += 3;
      if (bus16.in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL bp_in_ready_after: got %b expected 1", bus16.in_ready); end
      if (bus16.out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_no_phantom: got %b expected 0", bus16.out_valid); end
      if (bus16.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_busy_after: got %b expected 0", bus16.busy); end
   endtask

   task automatic test_reset_mid_op();
      logic [15:0] s;
      logic co, ov;
      int lat;
      bus16.a = 16'h8000;
      bus16.b = 16'h8000;
      bus16.cin = 1'b0;
      bus16.in_valid = 1'b1;
      @(negedge clk);
      bus16.in_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      vectors += 5;
      if (bus16.out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_out_valid: got %b expected 0", bus16.out_valid); end
      if (bus16.sum !== 16'h0) begin miscompares++; $display("[TB] FAIL midrst_sum: got %h expected 0000", bus16.sum); end
      if (bus16.cout !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_cout: got %b expected 0", bus16.cout); end
      if (bus16.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_busy: got %b expected 0", bus16.busy); end
      if (bus16.in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL midrst_in_ready: got %b expected 1", bus16.in_ready); end
      @(negedge clk);
      rst = 1'b0;
      run_op16(16'h0001, 16'h0001, 1'b0, 0, s, co, ov, lat);
      vectors += 3;
      if (s !== 16'h0002) begin miscompares++; $display("[TB] FAIL midrst_next_sum: got %h expected 0002", s); end
      if (co !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_next_cout: got %b expected 0", co); end
      if (lat != 4) begin miscompares++; $display("[TB] FAIL midrst_next_latency: got %0d expected 4", lat); end
   endtask

   task automatic test_ovf();
      logic [15:0] s;
      logic co, ov;
      int lat;
      run_op16(16'h7FFF, 16'h0001, 1'b0, 0, s, co, ov, lat);
      vectors += 2;
      if (s !== 16'h8000) begin miscompares++; $display("[TB] FAIL ovf1_sum: got %h expected 8000", s); end
      if (co !== 1'b0) begin miscompares++; $display("[TB] FAIL ovf1_cout: got %b expected 0", co); end
`ifdef CHUNKED_ADDER_OVF_EN
      vectors++;
      if (ov !== 1'b1) begin miscompares++; $display("[TB] FAIL ovf1_ovf: got %b expected 1", ov); end
`endif
      run_op16(16'hFFFF, 16'h0001, 1'b0, 0, s, co, ov, lat);
      vectors += 2;
      if (s !== 16'h0000) begin miscompares++; $display("[TB] FAIL ovf2_sum: got %h expected 0000", s); end
      if (co !== 1'b1) begin miscompares++; $display("[TB] FAIL ovf2_cout: got %b expected 1", co); end
`ifdef CHUNKED_ADDER_OVF_EN
      vectors++;
      if (ov !== 1'b0) begin miscompares++; $display("[TB] FAIL ovf2_ovf: got %b expected 0", ov); end
`endif
   endtask

   task automatic test_back_to_back();
      logic [15:0] a, b, s;
      logic cin, co, ov;
      logic [32:0] exp;
      int lat;
      for (int n = 0; n < 200; n++) begin
         a = 16'($urandom);
         b = 16'($urandom);
         cin = 1'($urandom);
         run_op16(a, b, cin, int'($urandom_range(0, 3)), s, co, ov, lat);
         exp = ref_add(16, {16'd0, a}, {16'd0, b}, cin);
         vectors += 3;
         if (s !== exp[15:0]) begin miscompares++; $display("[TB] FAIL rand16_sum: %h+%h+%b got %h expected %h", a, b, cin, s, exp[15:0]); end
         if (co !== exp[32]) begin miscompares++; $display("[TB] FAIL rand16_cout: %h+%h+%b got %b expected %b", a, b, cin, co, exp[32]); end
         if (lat != 4) begin miscompares++; $display("[TB] FAIL rand16_latency: got %0d expected 4", lat); end
`ifdef CHUNKED_ADDER_OVF_EN
         vectors++;
         if (ov !== ref_ovf(16, {16'd0, a}, {16'd0, b}, exp[31:0])) begin
            miscompares++;
            $display("[TB] FAIL rand16_ovf: %h+%h+%b got %b", a, b, cin, ov);
         end
`endif
      end
   endtask

   task automatic test_sweep_w8();
      logic [7:0] a, b;
      logic cin;
      logic [32:0] exp;
      int lat;
      for (int n = 0; n < 1000; n++) begin
         a = 8'($urandom);
         b = 8'($urandom);
         cin = 1'($urandom);
         bus8.a = a;
         bus8.b = b;
         bus8.cin = cin;
         bus8.in_valid = 1'b1;
         @(negedge clk);
         bus8.in_valid = 1'b0;
         bus8.a = ~a;
         lat = 0;
         while (bus8.out_valid !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
         end
         exp = ref_add(8, {24'd0, a}, {24'd0, b}, cin);
         vectors += 3;
         if (bus8.sum !== exp[7:0]) begin miscompares++; $display("[TB] FAIL w8_sum: %h+%h+%b got %h expected %h", a, b, cin, bus8.sum, exp[7:0]); end
         if (bus8.cout !== exp[32]) begin miscompares++; $display("[TB] FAIL w8_cout: %h+%h+%b got %b expected %b", a, b, cin, bus8.cout, exp[32]); end
         if (lat != 1) begin miscompares++; $display("[TB] FAIL w8_latency: got %0d expected 1", lat); end
         bus8.out_ready = 1'b1;
         @(negedge clk);
         bus8.out_ready = 1'b0;
      end
   endtask

   task automatic test_sweep_w32();
      logic [31:0] a, b;
      logic cin;
      logic [32:0] exp;
      int lat;
      for (int n = 0; n < 1000; n++) begin
         a = $urandom;
         b = (n % 50 == 0) ? ~a : $urandom;
         cin = 1'($urandom);
         bus32.a = a;
         bus32.b = b;
         bus32.cin = cin;
         bus32.in_valid = 1'b1;
         @(negedge clk);
         bus32.in_valid = 1'b0;
         bus32.b = ~b;
         lat = 0;
         while (bus32.out_valid !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
         end
         exp = ref_add(32, a, b, cin);
         vectors += 3;
         if (bus32.sum !== exp[31:0]) begin miscompares++; $display("[TB] FAIL w32_sum: %h+%h+%b got %h expected %h", a, b, cin, bus32.sum, exp[31:0]); end
         if (bus32.cout !== exp[32]) begin miscompares++; $display("[TB] FAIL w32_cout: %h+%h+%b got %b expected %b", a, b, cin, bus32.cout, exp[32]); end
         if (lat != 32) begin miscompares++; $display("[TB] FAIL w32_latency: got %0d expected 32", lat); end
         bus32.out_ready = 1'b1;
         @(negedge clk);
         bus32.out_ready = 1'b0;
      end
   endtask

   initial begin
      #3000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vectors = 0;
      miscompares = 0;
      rst = 1'b1;
      bus16.in_valid = 1'b0; bus16.a = '0; bus16.b = '0; bus16.cin = 1'b0; bus16.out_ready = 1'b0;
      bus8.in_valid  = 1'b0; bus8.a  = '0; bus8.b  = '0; bus8.cin  = 1'b0; bus8.out_ready  = 1'b0;
      bus32.in_valid = 1'b0; bus32.a = '0; bus32.b = '0; bus32.cin = 1'b0; bus32.out_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      $display("[TB] starting");
      test_reset();
      test_basic();
      test_wrap();
      test_backpressure();
      test_reset_mid_op();
      test_ovf();
      test_back_to_back();
      test_sweep_w8();
      test_sweep_w32();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
